// File: rtl/lsu_pkg.sv
// Shared encodings for mem_access_unit: access sizes, FSM state codes and byte-enable constants.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef logic [1:0] lsu_state_t;
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_RESP   = 2'b10;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_B1   = 4'b0010;
    localparam logic [3:0] BE_B2   = 4'b0100;
    localparam logic [3:0] BE_B3   = 4'b1000;
    localparam logic [3:0] BE_HL   = 4'b0011;
    localparam logic [3:0] BE_HH   = 4'b1100;
    localparam logic [3:0] BE_W    = 4'b1111;

    // True only for the seven byte-enable codes the memory understands.
    function automatic logic be_is_legal(input logic [3:0] be);
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3, BE_HL, BE_HH, BE_W: be_is_legal = 1'b1;
            default:                                       be_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_be_gen.sv
// be_gen: (size, byte offset) -> byte-enable and misalignment flag.
// With LSU_ALIGN_CHECK_EN defined, misaligned halves/words and the reserved size are flagged.
module be_gen
    import lsu_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_be,
    output logic       o_misalign
);

    // Decode byte lanes; without the align check, low offset bits are simply ignored.
    always_comb begin
        o_be       = BE_NONE;
        o_misalign = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                case (i_addr_lo)
                    2'b00:   o_be = BE_B0;
                    2'b01:   o_be = BE_B1;
                    2'b10:   o_be = BE_B2;
                    default: o_be = BE_B3;
                endcase
            end
            SZ_HALF: begin
                o_be = i_addr_lo[1] ? BE_HH : BE_HL;
`ifdef LSU_ALIGN_CHECK_EN
                o_misalign = i_addr_lo[0];
`endif
            end
            SZ_WORD: begin
                o_be = BE_W;
`ifdef LSU_ALIGN_CHECK_EN
                o_misalign = (i_addr_lo != 2'b00);
`endif
            end
            default: begin
`ifdef LSU_ALIGN_CHECK_EN
                o_be       = BE_NONE;
                o_misalign = 1'b1;
`else
                o_be       = BE_W;
                o_misalign = 1'b0;
`endif
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store initiator in front of the data memory.
// Define LSU_ALIGN_CHECK_EN to fault misaligned requests instead of truncating the offset.
module mem_access_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [9:0]  dm_addr,
    output logic [3:0]  dm_BE,
    output logic [31:0] dm_din,
    output logic        dm_wr,
    output logic        dm_signed,
    input  logic [31:0] dm_dout,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_misalign
);

    lsu_state_t  r_state;
    logic        r_req_ready;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [11:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_misalign;

    logic [3:0]  w_be_req;
    logic        w_mis_req;
    logic [3:0]  w_be_q;
    logic        w_mis_q;
    logic [3:0]  w_dm_be;
    logic [31:0] w_dm_din;
    logic        w_dm_wr;
    logic        w_dm_signed;
    logic        w_unused_bits;

    // Legality is judged on the incoming request; lanes are driven from the captured copy.
    be_gen u_be_req (
        .i_size     (req_size),
        .i_addr_lo  (req_addr[1:0]),
        .o_be       (w_be_req),
        .o_misalign (w_mis_req)
    );

    be_gen u_be_q (
        .i_size     (r_size),
        .i_addr_lo  (r_addr[1:0]),
        .o_be       (w_be_q),
        .o_misalign (w_mis_q)
    );

    assign w_unused_bits = ^{req_addr[31:12], w_be_req, w_mis_q};

    // Memory controls come only from state and captured request, so reset drops dm_wr at once.
    always_comb begin
        w_dm_be     = BE_NONE;
        w_dm_din    = 32'h0000_0000;
        w_dm_wr     = 1'b0;
        w_dm_signed = 1'b0;
        if (r_state == ST_ACCESS) begin
            w_dm_be     = w_be_q;
            w_dm_din    = r_wdata;
            w_dm_wr     = r_we & be_is_legal(w_be_q);
            w_dm_signed = r_signed;
        end else begin
            w_dm_be     = BE_NONE;
            w_dm_din    = 32'h0000_0000;
            w_dm_wr     = 1'b0;
            w_dm_signed = 1'b0;
        end
    end

    // Request capture, one-cycle memory access and response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_req_ready     <= 1'b1;
            r_we            <= 1'b0;
            r_size          <= SZ_BYTE;
            r_signed        <= 1'b0;
            r_addr          <= 12'h000;
            r_wdata         <= 32'h0000_0000;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= 32'h0000_0000;
            r_resp_misalign <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_we        <= req_we;
                        r_size      <= req_size;
                        r_signed    <= req_signed;
                        r_addr      <= req_addr[11:0];
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        if (w_mis_req) begin
                            r_state         <= ST_RESP;
                            r_resp_valid    <= 1'b1;
                            r_resp_rdata    <= 32'h0000_0000;
                            r_resp_misalign <= 1'b1;
                        end else begin
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_state         <= ST_RESP;
                    r_resp_valid    <= 1'b1;
                    r_resp_misalign <= 1'b0;
                    if (r_we) begin
                        r_resp_rdata <= 32'h0000_0000;
                    end else begin
                        r_resp_rdata <= dm_dout;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign dm_addr       = r_addr[11:2];
    assign dm_BE         = w_dm_be;
    assign dm_din        = w_dm_din;
    assign dm_wr         = w_dm_wr;
    assign dm_signed     = w_dm_signed;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign resp_misalign = r_resp_misalign;

endmodule
